dmem_port_arbiter: RTL and testbench

//  Shares the single-port data RAM between the pipeline MEM stage and a debug/loader port.
//  The CPU has priority. A waiting debug request is granted on any idle CPU cycle.
//  If the CPU keeps the RAM busy, the debug request is forced through after MAX_WAIT denied cycles by stalling the CPU for one cycle.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/arb_sat_counter.sv | 27 ++
 rtl/dmem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
// State encoding, default bus widths and the wait-counter width.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;
    localparam int WAIT_W     = 4;

    typedef enum logic {
        ARB_CPU   = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
// Used for the debug wait count and the optional performance counters.
module arb_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the MEM stage (priority) and a debug port.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [CNT_W-1:0]  perf_stall,
    output logic [CNT_W-1:0]  perf_dbg
);

    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] rdata_hold_q;

    logic cpu_act, dbg_sel, stall_raw, cnt_inc, cnt_clr;

    always_comb begin
        cpu_act   = cpu_rd | cpu_wr;
        dbg_sel   = 1'b0;
        stall_raw = 1'b0;
        cnt_inc   = 1'b0;
        state_d   = state_q;
        case (state_q)
            ARB_CPU: begin
                dbg_sel = dbg_req & ~cpu_act;
                cnt_inc = dbg_req & cpu_act;
                // Force on the denial that brings the count up to MAX_WAIT.
                if (cnt_inc && (wait_cnt_q == LAST_WAIT)) begin
                    state_d = ARB_FORCE;
                end
            end
            ARB_FORCE: begin
                dbg_sel   = dbg_req;
                stall_raw = cpu_act;
                state_d   = ARB_CPU;
            end
        endcase
        cnt_clr = ~cnt_inc;
    end

    // A stalled CPU store never reaches the RAM; it is replayed next cycle.
    always_comb begin
        if (dbg_sel) begin
            mem_addr = dbg_addr;
            mem_din  = dbg_wdata;
            mem_we   = dbg_we & ~reset;
        end else begin
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
            mem_we   = cpu_wr & (state_q == ARB_CPU) & ~reset;
        end
    end

    assign dbg_ack   = dbg_sel & ~reset;
    assign cpu_stall = stall_raw & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_CPU;
            dbg_rvalid_q <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            dbg_rvalid_q <= dbg_ack & ~dbg_we;
            if (dbg_rvalid_q) begin
                rdata_hold_q <= mem_dout;
            end
        end
    end

    arb_sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (cnt_inc),
        .clr_i (cnt_clr),
        .cnt_o (wait_cnt_q)
    );

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rvalid_q ? mem_dout : rdata_hold_q;
    assign cpu_rdata  = mem_dout;

`ifdef DMEM_ARB_PERF_EN
    arb_sat_counter #(.W(CNT_W)) u_perf_stall (
        .clk   (clk),
        .reset (reset),
        .en_i  (cpu_stall),
        .clr_i (1'b0),
        .cnt_o (perf_stall)
    );

    arb_sat_counter #(.W(CNT_W)) u_perf_dbg (
        .clk   (clk),
        .reset (reset),
        .en_i  (dbg_ack),
        .clr_i (1'b0),
        .cnt_o (perf_dbg)
    );
`else
    assign perf_stall = '0;
    assign perf_dbg   = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_dmem_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int CW = 4;
    localparam int PERF_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic          mem_we;
    logic [CW-1:0] perf_stall, perf_dbg;

    logic          ram_clr;
    logic [DW-1:0] ram [0:63];

    dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .perf_stall(perf_stall), .perf_dbg(perf_dbg)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
            mem_dout <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    // Reference model state
    int            n_vec = 0;
    int            n_err = 0;
    int            m_denied;
    bit            m_force;
    logic [DW-1:0] exp_ram [0:63];
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;
    bit            m_cpu_rv;
    logic [DW-1:0] m_cpu_rval;
    int            m_pstall, m_pdbg;
    bit            last_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already applied; check mid-cycle, then advance model.
    task automatic cycle();
        bit            cpu, ack, stall, we, dsel, busy;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        cpu = cpu_rd | cpu_wr;
        if (reset) begin
            dsel = 0; ack = 0; stall = 0; we = 0;
        end else if (m_force) begin
            dsel = dbg_req; ack = dbg_req; stall = cpu; we = dbg_req & dbg_we;
        end else if (cpu) begin
            dsel = 0; ack = 0; stall = 0; we = cpu_wr;
        end else begin
            dsel = dbg_req; ack = dbg_req; stall = 0; we = dbg_req & dbg_we;
        end
        a    = dsel ? dbg_addr : cpu_addr;
        d    = dsel ? dbg_wdata : cpu_wdata;
        busy = ack || (cpu && !stall && !reset && !m_force);
        last_ack = dbg_ack;

        chk("dbg_ack",    32'(dbg_ack),    32'(ack));
        chk("cpu_stall",  32'(cpu_stall),  32'(stall));
        chk("mem_we",     32'(mem_we),     32'(we));
        chk("dbg_rvalid", 32'(dbg_rvalid), reset ? 32'd0 : 32'(m_rvalid));
        chk("dbg_rdata",  dbg_rdata,       reset ? 32'd0 : m_rdata);
        if (busy || we) chk("mem_addr", 32'(mem_addr), 32'(a));
        if (we)         chk("mem_din",  mem_din, d);
        if (m_cpu_rv)   chk("cpu_rdata", cpu_rdata, m_cpu_rval);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall", 32'(perf_stall), reset ? 32'd0 : 32'(m_pstall));
        chk("perf_dbg",   32'(perf_dbg),   reset ? 32'd0 : 32'(m_pdbg));
`else
        chk("perf_stall", 32'(perf_stall), 32'd0);
        chk("perf_dbg",   32'(perf_dbg),   32'd0);
`endif

        if (reset) begin
            m_denied = 0; m_force = 0; m_rvalid = 0; m_rdata = '0;
            m_cpu_rv = 0; m_pstall = 0; m_pdbg = 0;
        end else begin
            m_cpu_rv   = cpu_rd & ~cpu_wr & ~stall & ~m_force;
            m_cpu_rval = exp_ram[cpu_addr];
            m_rvalid   = ack & ~dbg_we;
            if (m_rvalid) m_rdata = exp_ram[dbg_addr];
            if (stall && m_pstall < PERF_MAX) m_pstall++;
            if (ack && m_pdbg < PERF_MAX) m_pdbg++;
            if (m_force) begin
                m_force = 0; m_denied = 0;
            end else if (dbg_req && cpu) begin
                m_denied++;
                if (m_denied == MW) m_force = 1;
            end else begin
                m_denied = 0;
            end
            if (we) exp_ram[a] = d;
        end
        @(posedge clk);
        #1;
    endtask

    // Hold the current debug request until acked; check cycles-to-ack.
    task automatic run_until_ack(input string tag, input int exp_cycles);
        int n;
        bit got;
        n = 0; got = 0;
        while (!got && n < 20) begin
            cycle();
            n++;
            got = last_ack;
        end
        chk(tag, 32'(n), 32'(exp_cycles));
        dbg_req = 0;
    endtask

    initial begin
        reset = 1; ram_clr = 1;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < 64; i++) exp_ram[i] = '0;
        m_denied = 0; m_force = 0; m_rvalid = 0; m_rdata = '0;
        m_cpu_rv = 0; m_cpu_rval = '0; m_pstall = 0; m_pdbg = 0; last_ack = 0;
        #1;
        cycle();
        cycle();
        ram_clr = 0; reset = 0;

        // idle CPU: debug write then read of addr 5
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'd5; dbg_wdata = 32'hDEADBEEF;
        run_until_ack("dbg_wr_idle_lat", 1);
        dbg_req = 1; dbg_we = 0; dbg_addr = 6'd5;
        run_until_ack("dbg_rd_idle_lat", 1);
        cycle();
        chk("dbg_rdata_5", dbg_rdata, 32'hDEADBEEF);
        cycle();

        // CPU reads every cycle: debug read forced after MAX_WAIT denials
        cpu_rd = 1; cpu_addr = 6'd5;
        dbg_req = 1; dbg_we = 0; dbg_addr = 6'd5;
        run_until_ack("force_latency", MW + 1);
        cycle();
        cycle();
        cpu_rd = 0;

        // colliding stores: forced debug 0x22, replayed CPU 0x11
        cpu_wr = 1; cpu_addr = 6'd3; cpu_wdata = 32'h11;
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'd3; dbg_wdata = 32'h22;
        run_until_ack("collide_latency", MW + 1);
        cycle();
        cpu_wr = 0;
        cycle();
        chk("ram3_final", ram[3], 32'h11);

        // reset asserted during the forced slot
        cpu_rd = 1; cpu_addr = 6'd1;
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'd2; dbg_wdata = 32'hA5A5A5A5;
        repeat (MW) cycle();
        reset = 1;
        cycle();
        reset = 0;
        chk("ram2_after_reset", ram[2], 32'h0);
        run_until_ack("post_reset_latency", MW + 1);
        cycle();

        // request dropped after 2 denials, then re-raised
        dbg_req = 1; dbg_we = 0; dbg_addr = 6'd3;
        cycle();
        cycle();
        dbg_req = 0;
        cycle();
        dbg_req = 1;
        run_until_ack("reraise_latency", MW + 1);
        cpu_rd = 0;
        cycle();

        // randomized traffic
        for (int k = 0; k < 250; k++) begin
            int r;
            r = $urandom_range(0, 9);
            cpu_rd    = (r < 4) || (r == 8);
            cpu_wr    = (r >= 4 && r < 7) || (r == 8);
            cpu_addr  = AW'($urandom_range(0, 7));
            cpu_wdata = $urandom;
            if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req   = 1;
                dbg_we    = $urandom_range(0, 1) == 1;
                dbg_addr  = AW'($urandom_range(0, 7));
                dbg_wdata = $urandom;
            end
            cycle();
            if (last_ack) dbg_req = 0;
        end
        cpu_rd = 0; cpu_wr = 0; dbg_req = 0;
        cycle();

        // 20 forced stalls to push the perf counters past saturation
        cpu_rd = 1;
        for (int k = 0; k < 20; k++) begin
            dbg_req = 1; dbg_we = 0; dbg_addr = AW'(k % 8);
            run_until_ack("perf_force_latency", MW + 1);
        end
        cpu_rd = 0;
        cycle();
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall_sat", 32'(perf_stall), 32'd15);
        chk("perf_dbg_sat",   32'(perf_dbg),   32'd15);
`endif

        for (int i = 0; i < 8; i++) chk("ram_final", ram[i], exp_ram[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
